// File: rtl/mux_demux_pkg.sv
// Shared lane-count, select type and round-robin helper for the mux/demux routing stages.
package mux_demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] lane_sel_t;

  // First set bit of mask scanning base+1, base+2, ... (mod NUM_LANES); base itself ranks last.
  // Returns base when mask is empty.
  function automatic lane_sel_t rr_next(input logic [NUM_LANES-1:0] mask, input lane_sel_t base);
    lane_sel_t grant;
    lane_sel_t idx;
    grant = base;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = base + SEL_W'(k);
      if (mask[idx]) grant = idx;
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotate-priority encoder: picks the next occupied lane after base.
module rr_pick_4
  import mux_demux_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  input  lane_sel_t            base,
  output lane_sel_t            grant,
  output logic                 any
);

  // Grant lane and occupancy flag.
  always_comb begin
    grant = rr_next(mask, base);
    any   = |mask;
  end

endmodule

// File: rtl/rr_lane_sequencer_4.sv
// Per-lane 1-deep holding registers with round-robin grant onto the shared select.
module rr_lane_sequencer_4
  import mux_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_LANES-1:0]                in_valid,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]     in_data,
  output logic [NUM_LANES-1:0]                in_ready,
  output logic [NUM_LANES-1:0][WIDTH-1:0]     inp,
  output lane_sel_t                           sel,
  output logic                                out_valid,
  input  logic                                out_ready
);

  logic [NUM_LANES-1:0]            full_q, full_d;
  logic [NUM_LANES-1:0][WIDTH-1:0] inp_q, inp_d;
  lane_sel_t                       sel_q, sel_d;
  lane_sel_t                       ptr_q, ptr_d;
  logic                            out_valid_q, out_valid_d;

  logic                            fire;
  logic [NUM_LANES-1:0]            drain;
  logic [NUM_LANES-1:0]            capture;
  logic [NUM_LANES-1:0]            full_nxt;
  lane_sel_t                       pick_grant;
  logic                            pick_any;

  // Occupancy after this edge: drain the fired lane, then captures override (refill wins).
  always_comb begin
    fire  = out_valid_q & out_ready;
    drain = '0;
    if (fire) drain[sel_q] = 1'b1;
    in_ready = reset ? '0 : (~full_q | drain);
    capture  = in_valid & in_ready;
    full_nxt = capture | (full_q & ~drain);
    full_d   = full_nxt;
    inp_d    = inp_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (capture[i]) inp_d[i] = in_data[i];
    end
  end

  // Scan forward from the last granted lane so a refilled lane ranks behind all others.
  rr_pick_4 u_pick (
    .mask  (full_nxt),
    .base  (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Grant update only while the output slot is free or being consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    if (~out_valid_q | out_ready) begin
      out_valid_d = pick_any;
      if (pick_any) begin
        sel_d = pick_grant;
        ptr_d = pick_grant;
      end
    end
  end

  // State registers; ptr resets to the last lane so the first scan starts at lane 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q      <= '0;
      inp_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= lane_sel_t'(NUM_LANES - 1);
      out_valid_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      inp_q       <= inp_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign inp       = inp_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_lane_sequencer_4.sv
// Randomized and directed bench for rr_lane_sequencer_4 against a lane-occupancy model.
module tb_rr_lane_sequencer_4;

  logic             clock = 1'b0;
  logic             reset;
  logic [3:0]       in_valid;
  logic [3:0][1:0]  in_data;
  logic [3:0]       in_ready;
  logic [3:0][1:0]  inp;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: which lanes hold a word, the word values, and the current grant.
  bit m_full[4];
  int m_data[4];
  int m_sel;
  int m_ptr;
  bit m_ov;

  rr_lane_sequencer_4 #(.WIDTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .inp       (inp),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0;
      m_data[i] = 0;
    end
    m_sel = 0;
    m_ptr = 3;
    m_ov  = 0;
  endtask

  // Drive one cycle of inputs, compare every output with the model, advance both.
  task automatic step(input bit rst, input logic [3:0] iv, input logic [7:0] id, input bit ordy);
    int  exp_rdy[4];
    bit  fire;
    bit  found;
    int  lane;
    reset     = rst;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    fire = m_ov && ordy;
    for (int i = 0; i < 4; i++) begin
      exp_rdy[i] = (!rst && (!m_full[i] || (fire && m_sel == i))) ? 1 : 0;
      check($sformatf("in_ready[%0d]", i), int'(in_ready[i]), exp_rdy[i]);
      check($sformatf("inp[%0d]", i), int'(inp[i]), m_data[i]);
    end
    check("out_valid", int'(out_valid), int'(m_ov));
    check("sel", int'(sel), m_sel);
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fire && m_sel == i) m_full[i] = 0;
        if (iv[i] && exp_rdy[i] == 1) begin
          m_full[i] = 1;
          m_data[i] = int'(id[2*i +: 2]);
        end
      end
      if (!m_ov || ordy) begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          lane = (m_ptr + k) % 4;
          if (!found && m_full[lane]) begin
            found = 1;
            m_sel = lane;
            m_ptr = lane;
          end
        end
        m_ov = found;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int prev;
    int held;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock);

    // Reset held, then released with no traffic.
    step(1, 4'h0, 8'h00, 0);
    step(0, 4'h0, 8'h00, 0);
    check("t1_in_ready", int'(in_ready), 15);
    check("t1_out_valid", int'(out_valid), 0);

    // Single word on lane 2.
    step(0, 4'b0100, 8'h20, 1);
    check("t2_valid", int'(out_valid), 1);
    check("t2_sel", int'(sel), 2);
    check("t2_inp2", int'(inp[2]), 2);
    step(0, 4'h0, 8'h00, 1);
    check("t2_valid_after", int'(out_valid), 0);
    check("t2_in_ready2", int'(in_ready[2]), 1);

    // All lanes loaded together drain in order 0..3.
    step(1, 4'h0, 8'h00, 0);
    step(0, 4'hF, 8'($urandom), 1);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("t3_sel%0d", g), int'(sel), g);
      check($sformatf("t3_valid%0d", g), int'(out_valid), 1);
      step(0, 4'h0, 8'h00, 1);
    end
    check("t3_idle", int'(out_valid), 0);

    // Backpressure on lane 1 while lane 3 fills.
    step(1, 4'h0, 8'h00, 0);
    step(0, 4'b0010, 8'($urandom), 0);
    check("t4_sel_first", int'(sel), 1);
    held = int'(inp[1]);
    for (int c = 0; c < 3; c++) begin
      step(0, 4'b1000, 8'($urandom), 0);
      check("t4_sel_hold", int'(sel), 1);
      check("t4_inp1_hold", int'(inp[1]), held);
      check("t4_in_ready1", int'(in_ready[1]), 0);
    end
    step(0, 4'h0, 8'h00, 1);
    check("t4_sel_next", int'(sel), 3);
    check("t4_valid_next", int'(out_valid), 1);
    step(0, 4'h0, 8'h00, 1);

    // Lanes 0 and 3 pushed every cycle alternate grants.
    step(1, 4'h0, 8'h00, 0);
    prev = -1;
    for (int c = 0; c < 12; c++) begin
      step(0, 4'b1001, 8'($urandom), 1);
      check("t5_valid", int'(out_valid), 1);
      if (c == 0) check("t5_first", int'(sel), 0);
      else check("t5_alternate", int'(int'(sel) != prev), 1);
      prev = int'(sel);
    end

    // Reset mid-operation, then first grant scans from lane 0.
    step(1, 4'h0, 8'h00, 0);
    step(0, 4'b0110, 8'($urandom), 0);
    check("t6_sel_pre", int'(sel), 1);
    step(0, 4'h0, 8'h00, 0);
    step(1, 4'h0, 8'h00, 0);
    check("t6_valid_cleared", int'(out_valid), 0);
    step(0, 4'h0, 8'h00, 0);
    check("t6_all_ready", int'(in_ready), 15);
    step(0, 4'b0100, 8'h20, 1);
    check("t6_sel2", int'(sel), 2);
    step(0, 4'b0101, 8'($urandom), 1);
    check("t6_sel0", int'(sel), 0);

    // Random traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 49) == 0, 4'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
